// File: rtl/div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div
// Purpose  : Iterative signed restoring divider (quotient -> lo, remainder -> hi)
// Revision : 1.0
// ============================================================================
module div #(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             divControl,
    output logic             divStop,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_quo;
    logic [WIDTH-1:0]  r_dvs;
    logic              r_sign_q;
    logic              r_sign_r;

    logic [WIDTH-1:0]  w_abs_a;
    logic [WIDTH-1:0]  w_abs_b;
    logic [WIDTH:0]    w_rem_sh;
    logic [WIDTH:0]    w_trial;
    logic [WIDTH-1:0]  w_lo;
    logic [WIDTH-1:0]  w_hi;

    assign w_abs_a  = a[WIDTH-1] ? -a : a;
    assign w_abs_b  = b[WIDTH-1] ? -b : b;
    // Partial remainder always stays below the divisor, so WIDTH bits hold it.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvs};
    assign w_lo     = r_sign_q ? -r_quo : r_quo;
    assign w_hi     = r_sign_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (divControl) begin
            w_next = (b == '0) ? S_ZERO : S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (r_cnt == c_CW'(1)) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                S_ZERO:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            divStop  <= 1'b0;
            divZero  <= 1'b0;
        end else begin
            divStop <= 1'b0;
            divZero <= 1'b0;
            if (divControl) begin
                // Any sampled start restarts, abandoning an operation in flight.
                r_quo    <= w_abs_a;
                r_dvs    <= w_abs_b;
                r_rem    <= '0;
                r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                r_sign_r <= a[WIDTH-1];
                r_cnt    <= c_CW'(STEPS);
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                    S_DONE: begin
                        lo      <= w_lo;
                        hi      <= w_hi;
                        divStop <= 1'b1;
                    end
                    S_ZERO: begin
                        divZero <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div
// Purpose  : Directed and random checks of the signed iterative divider
// Revision : 1.0
// ============================================================================
module tb_div;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        divControl;
    logic        divStop;
    logic        divZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_err    = 0;
    int n_stop   = 0;
    int n_zero   = 0;

    always #5 clk = ~clk;

    div #(.WIDTH(32), .STEPS(32)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .divControl (divControl),
        .divStop    (divStop),
        .divZero    (divZero),
        .hi         (hi),
        .lo         (lo)
    );

    always @(negedge clk) begin
        if (divStop) n_stop++;
        if (divZero) n_zero++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents operands and a one-cycle start; returns #1 after the start edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a          = av;
        b          = bv;
        divControl = 1'b1;
        @(posedge clk);
        #1 divControl = 1'b0;
    endtask

    // Returns #1 after edge 33 following the start edge.
    task automatic finish_op(input string tag);
        repeat (32) @(posedge clk);
        #1 check_eq({tag, "_early"}, {31'b0, divStop}, 32'd0);
        @(posedge clk);
        #1 check_eq({tag, "_stop"}, {31'b0, divStop}, 32'd1);
    endtask

    task automatic run_dir(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] elo, input logic [31:0] ehi);
        start_op(av, bv);
        finish_op(tag);
        check_eq({tag, "_lo"}, lo, elo);
        check_eq({tag, "_hi"}, hi, ehi);
        @(posedge clk);
        #1 check_eq({tag, "_stopclr"}, {31'b0, divStop}, 32'd0);
        check_eq({tag, "_lohold"}, lo, elo);
        check_eq({tag, "_hihold"}, hi, ehi);
    endtask

    initial begin
        int          s, z;
        logic [31:0] av, bv, ah, ab;

        reset      = 1'b0;
        a          = '0;
        b          = '0;
        divControl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        check_eq("rst_stop", {31'b0, divStop}, 32'd0);
        check_eq("rst_zero", {31'b0, divZero}, 32'd0);
        @(negedge clk) reset = 1'b1;

        run_dir("pp", 32'd100, 32'd7, 32'd14, 32'd2);

        s = n_stop;
        z = n_zero;
        start_op(32'd5, 32'd0);
        @(posedge clk);
        #1 check_eq("z_pulse", {31'b0, divZero}, 32'd1);
        check_eq("z_nostop", {31'b0, divStop}, 32'd0);
        @(posedge clk);
        #1 check_eq("z_clr", {31'b0, divZero}, 32'd0);
        repeat (36) @(posedge clk);
        #1 check_eq("z_stopcnt", n_stop, s);
        check_eq("z_zerocnt", n_zero, z + 1);
        check_eq("z_lo", lo, 32'd14);
        check_eq("z_hi", hi, 32'd2);

        run_dir("np", 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_dir("pn", 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
        run_dir("nn", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE);

        s = n_stop;
        z = n_zero;
        start_op(32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("mr_lo", lo, 32'd0);
        check_eq("mr_hi", hi, 32'd0);
        check_eq("mr_stop", {31'b0, divStop}, 32'd0);
        check_eq("mr_zero", {31'b0, divZero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (40) @(posedge clk);
        #1 check_eq("mr_stopcnt", n_stop, s);
        check_eq("mr_zerocnt", n_zero, z);
        run_dir("mr_93", 32'd9, 32'd3, 32'd3, 32'd0);

        run_dir("ovf",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_dir("min1", 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0);
        run_dir("small", 32'd7, 32'd100, 32'd0, 32'd7);
        run_dir("m1by2", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
        run_dir("maxmin", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF);

        s = n_stop;
        start_op(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        start_op(32'd50, 32'd6);
        finish_op("abort");
        check_eq("abort_nostop", n_stop, s);
        check_eq("abort_lo", lo, 32'd8);
        check_eq("abort_hi", hi, 32'd2);
        @(posedge clk);
        #1 check_eq("abort_stopclr", {31'b0, divStop}, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            av = $urandom;
            bv = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(1, 50));
            if ($urandom_range(0, 1) != 0) bv = -bv;
            if (bv == 32'd0) bv = 32'd1;
            start_op(av, bv);
            finish_op("rnd");
            check_eq("rnd_ident", lo * bv + hi, av);
            ah = hi[31] ? -hi : hi;
            ab = bv[31] ? -bv : bv;
            check_eq("rnd_mag", {31'b0, (ah < ab)}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
